// File: rtl/gpi_debounce.sv
// Per-bit synchroniser and debouncer for board buttons and switches.
// Reports the debounced level plus one-cycle rise and fall pulses per bit.
module gpi_debounce #(
  parameter int unsigned       Width          = 20,
  parameter int unsigned       DebounceCycles = 50000,
  parameter logic [Width-1:0]  ResetValue     = '0
) (
  input  logic             clk_sys_i,
  input  logic             rst_sys_ni,
  input  logic [Width-1:0] raw_i,
  output logic [Width-1:0] gp_o,
  output logic [Width-1:0] rise_o,
  output logic [Width-1:0] fall_o
);

  localparam int unsigned CntWidth = $clog2(DebounceCycles + 1);
  localparam logic [CntWidth-1:0] CntLast = CntWidth'(DebounceCycles - 1);

  logic [Width-1:0]    s1_q, s2_q;
  logic [Width-1:0]    gp_q, gp_d;
  logic [Width-1:0]    rise_q, rise_d;
  logic [Width-1:0]    fall_q, fall_d;
  logic [CntWidth-1:0] cnt_q [Width];
  logic [CntWidth-1:0] cnt_d [Width];

  // Accept a change only after DebounceCycles consecutive mismatching compares.
  always_comb begin
    gp_d   = gp_q;
    rise_d = '0;
    fall_d = '0;
    for (int i = 0; i < int'(Width); i++) begin
      cnt_d[i] = cnt_q[i];
      if (s2_q[i] == gp_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CntLast) begin
        gp_d[i]   = s2_q[i];
        cnt_d[i]  = '0;
        rise_d[i] = s2_q[i];
        fall_d[i] = ~s2_q[i];
      end else begin
        cnt_d[i] = cnt_q[i] + CntWidth'(1);
      end
    end
  end

  // Synchroniser stages share ResetValue with gp so reset produces no edge.
  always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
    if (!rst_sys_ni) begin
      s1_q   <= ResetValue;
      s2_q   <= ResetValue;
      gp_q   <= ResetValue;
      rise_q <= '0;
      fall_q <= '0;
      for (int i = 0; i < int'(Width); i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      s1_q   <= raw_i;
      s2_q   <= s1_q;
      gp_q   <= gp_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
      for (int i = 0; i < int'(Width); i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign gp_o   = gp_q;
  assign rise_o = rise_q;
  assign fall_o = fall_q;

endmodule

// File: tb/tb_gpi_debounce.sv
// Self-checking bench for gpi_debounce: directed scenarios plus a randomized
// run checked against a sample-window reference model.
module tb_gpi_debounce;

  localparam int unsigned W  = 4;
  localparam int unsigned DC = 4;
  localparam logic [W-1:0] RV = '0;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] raw;
  logic [W-1:0] gp, rise, fall;

  int n_tests = 0;
  int n_fail  = 0;

  gpi_debounce #(.Width(W), .DebounceCycles(DC), .ResetValue(RV)) dut (
    .clk_sys_i (clk),
    .rst_sys_ni(rst_n),
    .raw_i     (raw),
    .gp_o      (gp),
    .rise_o    (rise),
    .fall_o    (fall)
  );

  always #5 clk = ~clk;

  // Reference: a bit flips once the last DC synchronised samples all differ from it.
  logic [W-1:0] rq[$];
  logic [W-1:0] wq[$];
  logic [W-1:0] m_gp, m_rise, m_fall;

  always @(posedge clk or negedge rst_n) begin
    logic [W-1:0] s2v;
    logic         all_differ;
    if (!rst_n) begin
      rq = {RV, RV};
      wq = {};
      m_gp = RV;
      m_rise = '0;
      m_fall = '0;
    end else begin
      s2v = rq[0];
      void'(rq.pop_front());
      rq.push_back(raw);
      wq.push_back(s2v);
      if (wq.size() > DC) void'(wq.pop_front());
      m_rise = '0;
      m_fall = '0;
      if (wq.size() == DC) begin
        for (int b = 0; b < int'(W); b++) begin
          all_differ = 1'b1;
          foreach (wq[j]) if (wq[j][b] == m_gp[b]) all_differ = 1'b0;
          if (all_differ) begin
            m_gp[b]   = s2v[b];
            m_rise[b] = s2v[b];
            m_fall[b] = ~s2v[b];
          end
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    raw   = '0;
    repeat (2) tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    raw   = 4'hF;
    repeat (3) tick();
    n_tests++;
    if (gp !== 4'h0 || rise !== 4'h0 || fall !== 4'h0) begin
      $display("FAIL reset_hold gp=%h rise=%h fall=%h expected 0/0/0", gp, rise, fall);
      n_fail++;
    end
    rst_n = 1'b1;
    repeat (5) tick();
    n_tests++;
    if (gp !== 4'h0 || rise !== 4'h0) begin
      $display("FAIL reset_early gp=%h rise=%h expected 0/0", gp, rise);
      n_fail++;
    end
    tick();
    n_tests++;
    if (gp !== 4'hF || rise !== 4'hF || fall !== 4'h0) begin
      $display("FAIL reset_release gp=%h rise=%h fall=%h expected F/F/0", gp, rise, fall);
      n_fail++;
    end
    tick();
    n_tests++;
    if (gp !== 4'hF || rise !== 4'h0) begin
      $display("FAIL reset_pulse_end gp=%h rise=%h expected F/0", gp, rise);
      n_fail++;
    end
  endtask

  task automatic test_clean_press;
    do_reset();
    raw = 4'b0001;
    repeat (5) tick();
    n_tests++;
    if (gp !== 4'h0 || rise !== 4'h0) begin
      $display("FAIL press_early gp=%h rise=%h expected 0/0", gp, rise);
      n_fail++;
    end
    tick();
    n_tests++;
    if (gp !== 4'b0001 || rise !== 4'b0001 || fall !== 4'h0) begin
      $display("FAIL press_accept gp=%h rise=%h fall=%h expected 1/1/0", gp, rise, fall);
      n_fail++;
    end
    tick();
    n_tests++;
    if (gp !== 4'b0001 || rise !== 4'h0) begin
      $display("FAIL press_pulse_end gp=%h rise=%h expected 1/0", gp, rise);
      n_fail++;
    end
    raw = 4'b0000;
    repeat (5) tick();
    n_tests++;
    if (gp !== 4'b0001 || fall !== 4'h0) begin
      $display("FAIL release_early gp=%h fall=%h expected 1/0", gp, fall);
      n_fail++;
    end
    tick();
    n_tests++;
    if (gp !== 4'h0 || fall !== 4'b0001 || rise !== 4'h0) begin
      $display("FAIL release_accept gp=%h fall=%h rise=%h expected 0/1/0", gp, fall, rise);
      n_fail++;
    end
    tick();
    n_tests++;
    if (fall !== 4'h0) begin
      $display("FAIL release_pulse_end fall=%h expected 0", fall);
      n_fail++;
    end
  endtask

  task automatic test_glitch;
    do_reset();
    raw = 4'b0010;
    repeat (3) tick();
    raw = 4'b0000;
    for (int c = 0; c < 10; c++) begin
      tick();
      n_tests++;
      if (gp !== 4'h0 || rise !== 4'h0 || fall !== 4'h0) begin
        $display("FAIL glitch_reject cyc=%0d gp=%h rise=%h fall=%h expected 0/0/0", c, gp, rise, fall);
        n_fail++;
      end
    end
    raw = 4'b0010;
    repeat (3) tick();
    raw = 4'b0000;
    tick();
    raw = 4'b0010;
    repeat (5) tick();
    n_tests++;
    if (gp !== 4'h0 || rise !== 4'h0) begin
      $display("FAIL glitch_restart_early gp=%h rise=%h expected 0/0", gp, rise);
      n_fail++;
    end
    tick();
    n_tests++;
    if (gp !== 4'b0010 || rise !== 4'b0010) begin
      $display("FAIL glitch_restart_accept gp=%h rise=%h expected 2/2", gp, rise);
      n_fail++;
    end
  endtask

  task automatic test_independent;
    do_reset();
    raw = 4'b1100;
    repeat (6) tick();
    n_tests++;
    if (gp !== 4'b1100 || rise !== 4'b1100) begin
      $display("FAIL indep_rise gp=%h rise=%h expected C/C", gp, rise);
      n_fail++;
    end
    for (int c = 0; c < 12; c++) begin
      raw[3] = ~raw[3];
      tick();
      n_tests++;
      if (gp !== 4'b1100 || fall !== 4'h0 || rise !== 4'h0) begin
        $display("FAIL indep_bounce cyc=%0d gp=%h rise=%h fall=%h expected C/0/0", c, gp, rise, fall);
        n_fail++;
      end
    end
  endtask

  task automatic test_reset_mid;
    do_reset();
    raw = 4'b0010;
    repeat (7) tick();
    raw = 4'b0011;
    repeat (3) tick();
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if (gp !== 4'h0 || rise !== 4'h0 || fall !== 4'h0) begin
      $display("FAIL midreset_async gp=%h rise=%h fall=%h expected 0/0/0", gp, rise, fall);
      n_fail++;
    end
    tick();
    rst_n = 1'b1;
    repeat (5) tick();
    n_tests++;
    if (gp !== 4'h0 || rise !== 4'h0) begin
      $display("FAIL midreset_early gp=%h rise=%h expected 0/0", gp, rise);
      n_fail++;
    end
    tick();
    n_tests++;
    if (gp !== 4'b0011 || rise !== 4'b0011) begin
      $display("FAIL midreset_accept gp=%h rise=%h expected 3/3", gp, rise);
      n_fail++;
    end
  endtask

  task automatic test_random;
    logic [W-1:0] prev_gp;
    do_reset();
    prev_gp = gp;
    for (int c = 0; c < 10000; c++) begin
      for (int b = 0; b < int'(W); b++)
        if ($urandom_range(7) == 0) raw[b] = ~raw[b];
      tick();
      n_tests++;
      if (gp !== m_gp || rise !== m_rise || fall !== m_fall) begin
        $display("FAIL rand_model cyc=%0d gp=%h rise=%h fall=%h expected %h/%h/%h",
                 c, gp, rise, fall, m_gp, m_rise, m_fall);
        n_fail++;
      end
      n_tests++;
      if ((rise & fall) !== 4'h0) begin
        $display("FAIL rand_exclusive cyc=%0d rise&fall=%h expected 0", c, rise & fall);
        n_fail++;
      end
      n_tests++;
      if ((rise | fall) !== (gp ^ prev_gp) || (rise & ~gp) !== 4'h0) begin
        $display("FAIL rand_pulse_align cyc=%0d pulses=%h expected %h", c, rise | fall, gp ^ prev_gp);
        n_fail++;
      end
      prev_gp = gp;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    raw   = '0;
    test_reset();
    test_clean_press();
    test_glitch();
    test_independent();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/gpi_debounce.md
# gpi_debounce

Input conditioner for the demo system's general-purpose inputs. It synchronises the raw board buttons and switches into `clk_sys_i`, debounces each bit independently, and reports per-bit rising and falling edges. It sits between the board pins and the demo system's `gp_i`. `gp_o` drives `gp_i` directly; the edge pulses are available for interrupt or event logic.

## Interface
- `Width`, default 20: number of input bits (BTN + SW).
- `DebounceCycles`, default 50000: number of consecutive stable `clk_sys_i` cycles required to accept a change. Must be at least 1.
- `ResetValue`, default '0: value of the synchroniser flops and `gp_o` during reset.
- `CntWidth`, derived, not overridable: `$clog2(DebounceCycles+1)`.

Ports:
- `clk_sys_i`, in, 1: system clock; the only clock.
- `rst_sys_ni`, in, 1: reset. Asynchronous assert, active-low.
- `raw_i`, in, `Width`: raw pin levels, asynchronous to `clk_sys_i`.
- `gp_o`, out, `Width`: debounced level, registered.
- `rise_o`, out, `Width`: one-cycle pulse on each accepted 0→1 change, registered.
- `fall_o`, out, `Width`: one-cycle pulse on each accepted 1→0 change, registered.

## Operation
**Synchroniser**
- Two flops per bit: `raw_i` → `s1` → `s2`.
- Both stages reset to `ResetValue`, so no spurious edge is reported after reset.

**Per-bit debounce**
- Each bit has its own `CntWidth`-bit counter `cnt` and a state flop that drives `gp_o`. Bits never interact.
- Every cycle, per bit:
  - If `s2 == gp_o`: `cnt <= 0`.
  - Else if `cnt == DebounceCycles-1`: `gp_o <= s2`, `cnt <= 0`, and pulse `rise_o` (if `s2`=1) or `fall_o` (if `s2`=0).
  - Else: `cnt <= cnt + 1`.

**Behaviour rules**
- Any return of `s2` to the current `gp_o` value, for even one cycle, clears the counter. A glitch shorter than `DebounceCycles` cycles never reaches `gp_o`.
- `rise_o` and `fall_o` assert only in the cycle `gp_o` changes. They are mutually exclusive per bit and never asserted for two consecutive cycles on the same bit.
- `cnt` never exceeds `DebounceCycles-1`, so there is no wrap-around.
- `DebounceCycles`=1: a change is accepted on the first compare cycle after `s2` differs.

**Reset**
- Asserting `rst_sys_ni` mid-count immediately forces `gp_o`=`ResetValue`, `rise_o`=0, `fall_o`=0, all `cnt`=0, and `s1`=`s2`=`ResetValue`. Pending changes are discarded.
- After release, if `raw_i` differs from `ResetValue`, the full latency below applies and the corresponding edge is reported.

## Timing
- `raw_i` settles before rising edge k. Then `s1` updates at k and `s2` at k+1.
- Compares run on edges k+2 … k+1+DebounceCycles. `gp_o` and the edge pulse update at edge k+1+DebounceCycles, which is a latency of DebounceCycles+2 edges.
- Each edge pulse is high for exactly one cycle, aligned with the first cycle of the new `gp_o` value.
- Outputs are registered, with no combinational path from `raw_i`.
- Reset is asynchronous on assert. Release must be synchronised by the clock generator (`rst_sys_n` already is).

## Test plan
Bench configuration for all scenarios: `Width`=4, `DebounceCycles`=4, `ResetValue`=0.

- **Reset state:** hold `rst_sys_ni`=0 with `raw_i`=4'hF → `gp_o`=0, `rise_o`=0, `fall_o`=0. Release → `gp_o`=4'hF exactly 6 edges later, with `rise_o`=4'hF for one cycle.
- **Clean press:** `raw_i[0]` 0→1, held → `gp_o[0]`=1 on the 6th edge, and `rise_o`=4'b0001 for exactly one cycle. `gp_o[0]` 1→0 later → `fall_o`=4'b0001 after 6 edges.
- **Glitch rejection:** pulse `raw_i[1]` high for 3 cycles, then low → `gp_o[1]` stays 0 and no pulses. High 3 cycles, low 1, high 4+ → `gp_o[1]` rises only after 4 uninterrupted cycles at `s2`.
- **Independent bits:** `raw_i[2]` and `raw_i[3]` toggle on the same edge → both rise on the same cycle, `rise_o`=4'b1100. `raw_i[3]` bouncing while `raw_i[2]` is stable → `gp_o[2]` is unaffected.
- **Reset mid-count:** `raw_i[0]`=1 for 3 cycles, then assert reset for 1 cycle while `raw_i` is held → `gp_o`=0 asynchronously. After release, a full 6-edge latency applies before `gp_o[0]`=1.
- **Edge exclusivity:** random `raw_i` for 10k cycles, compared against a reference model → `rise_o & fall_o` is always 0, each pulse coincides with a `gp_o` change, and `gp_o` matches the model.
